// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helpers for the serial packed-BCD adder.
package bcd_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned WORD_DIGITS = 4;
    localparam int unsigned WORD_W      = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Per-digit nines complement; only meaningful for valid BCD digits.
    function automatic logic [WORD_W-1:0] nines_word(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int i = 0; i < WORD_DIGITS; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = 4'd9 - w[i*DIGIT_W +: DIGIT_W];
        end
        return r;
    endfunction

    function automatic logic bcd_word_valid(input logic [WORD_W-1:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WORD_DIGITS; i++) begin
            if (w[i*DIGIT_W +: DIGIT_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_word_adder.sv
// Combinational 4-digit packed-BCD adder with decimal carry in and out.
module bcd_word_adder
    import bcd_pkg::*;
(
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    input  logic              cin_i,
    output logic [WORD_W-1:0] sum_o,
    output logic              cout_o
);

    logic       c;
    logic [4:0] s;

    always_comb begin
        c     = cin_i;
        s     = '0;
        sum_o = '0;
        for (int i = 0; i < WORD_DIGITS; i++) begin
            s = {1'b0, a_i[i*DIGIT_W +: DIGIT_W]} + {1'b0, b_i[i*DIGIT_W +: DIGIT_W]} + {4'b0, c};
            // Binary digit sum is at most 19; adding 6 folds 10..19 back into 0..9 with a carry.
            if (s > 5'd9) begin
                s = s + 5'd6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            sum_o[i*DIGIT_W +: DIGIT_W] = s[3:0];
        end
        cout_o = c;
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Wide packed-BCD add/subtract sequencer: one shared 4-digit word adder stepped across
// NUM_WORDS words, least-significant first, with the decimal carry chained in a register.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned W         = 16 * NUM_WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    input  logic         sub,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         err
);

    localparam int unsigned IdxW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;
    logic            res_valid_q, res_valid_d;

    logic [W-1:0]      b_nines;
    logic              ops_ok;
    logic [WORD_W-1:0] word_a, word_b, word_sum;
    logic              word_cout;

    always_comb begin
        ops_ok  = 1'b1;
        b_nines = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            ops_ok = ops_ok & bcd_word_valid(op_a[WORD_W*i +: WORD_W])
                            & bcd_word_valid(op_b[WORD_W*i +: WORD_W]);
            b_nines[WORD_W*i +: WORD_W] = nines_word(op_b[WORD_W*i +: WORD_W]);
        end
    end

    assign word_a = a_q[WORD_W*int'(idx_q) +: WORD_W];
    assign word_b = b_q[WORD_W*int'(idx_q) +: WORD_W];

    bcd_word_adder u_word_adder (
        .a_i    (word_a),
        .b_i    (word_b),
        .cin_i  (carry_q),
        .sum_o  (word_sum),
        .cout_o (word_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d      = op_a;
                    b_d      = sub ? b_nines : op_b;
                    // Subtraction is A + nines(B) + 1, so the +1 rides in as the first carry.
                    carry_d  = sub ? 1'b1 : cin;
                    idx_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    if (!ops_ok) begin
                        err_d       = 1'b1;
                        res_valid_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                result_d[WORD_W*int'(idx_q) +: WORD_W] = word_sum;
                carry_d = word_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IdxW'(NUM_WORDS - 1)) begin
                    idx_d       = '0;
                    cout_d      = word_cout;
                    res_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign res_valid   = res_valid_q;
    assign result      = result_q;
    assign cout        = cout_q;
    assign err         = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench: directed and random operations against a decimal-arithmetic model.
module tb_bcd_serial_adder_ctrl;

    localparam int unsigned NW = 4;
    localparam int unsigned W  = 16 * NW;
    localparam int unsigned ND = 4 * NW;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_serial_adder_ctrl #(.NUM_WORDS(NW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned bcd2int(input logic [W-1:0] v);
        longint unsigned r;
        r = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            r = r * 10 + longint'(v[4*i +: 4]);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint unsigned x);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input logic allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        if (allow_bad) r[4*$urandom_range(0, ND-1) +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    // Decimal reference: operate on the numeric values, not on digits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, output logic [W-1:0] e_res, output logic e_cout,
                         output logic e_err);
        longint unsigned pw, av, bv, s;
        pw = 1;
        for (int i = 0; i < ND; i++) pw = pw * 10;
        av = bcd2int(a);
        bv = bcd2int(b);
        e_err = has_bad_digit(a) || has_bad_digit(b);
        if (e_err) begin
            e_res  = '0;
            e_cout = 1'b0;
        end else if (!sb) begin
            s      = av + bv + longint'(ci);
            e_cout = (s >= pw);
            e_res  = int2bcd(s % pw);
        end else if (av >= bv) begin
            e_cout = 1'b1;
            e_res  = int2bcd(av - bv);
        end else begin
            e_cout = 1'b0;
            e_res  = int2bcd(pw - (bv - av));
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, input int hold, input string tag);
        logic [W-1:0] e_res;
        logic         e_cout, e_err;
        int           lat;
        model(a, b, ci, sb, e_res, e_cout, e_err);
        @(negedge clk);
        check_eq({tag, ".start_ready_idle"}, 64'(start_ready), 64'd1);
        op_a        = a;
        op_b        = b;
        cin         = ci;
        sub         = sb;
        start_valid = 1'b1;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        op_a        = {$urandom, $urandom};
        op_b        = {$urandom, $urandom};
        cin         = ~ci;
        sub         = ~sb;
        lat         = 1;
        while (!res_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 64'(lat), e_err ? 64'd1 : 64'(NW + 1));
        check_eq({tag, ".result"}, 64'(result), 64'(e_res));
        check_eq({tag, ".cout"}, 64'(cout), 64'(e_cout));
        check_eq({tag, ".err"}, 64'(err), 64'(e_err));
        check_eq({tag, ".start_ready_done"}, 64'(start_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            start_valid = 1'($urandom_range(0, 1));
            op_a        = rand_bcd(1'b0);
            @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, 64'(res_valid), 64'd1);
            check_eq({tag, ".hold_result"}, 64'(result), 64'(e_res));
            check_eq({tag, ".hold_cout"}, 64'(cout), 64'(e_cout));
            check_eq({tag, ".hold_start_ready"}, 64'(start_ready), 64'd0);
        end
        @(negedge clk);
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check_eq({tag, ".handoff_valid"}, 64'(res_valid), 64'd0);
        check_eq({tag, ".handoff_idle"}, 64'(start_ready), 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        op_a        = '0;
        op_b        = '0;
        cin         = 1'b0;
        sub         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.res_valid", 64'(res_valid), 64'd0);
        check_eq("reset.result", 64'(result), 64'd0);
        check_eq("reset.cout", 64'(cout), 64'd0);
        check_eq("reset.err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset.start_ready", 64'(start_ready), 64'd1);

        run_op(64'h0000_0000_0000_9999, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, "add_ripple");
        run_op(64'h9999_9999_9999_9999, 64'h0, 1'b1, 1'b0, 0, "add_all9_cin");
        run_op(64'h0000_0000_0000_0100, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 0, "sub_pos");
        run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b1, 0, "sub_neg");
        run_op(64'h0000_0000_0000_00A0, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, "bad_digit");
        run_op(64'h1234_5678_9012_3456, 64'h1234_5678_9012_3456, 1'b0, 1'b1, 0, "sub_equal");
        run_op(64'h5555_0000_1234_8765, 64'h4444_9999_8765_1234, 1'b0, 1'b0, 3, "hold_done");

        // Abort in the second RUN cycle; outputs must clear before any clock edge.
        @(negedge clk);
        op_a        = 64'h0000_0000_1234_5678;
        op_b        = 64'h0000_0000_1111_1111;
        cin         = 1'b0;
        sub         = 1'b0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("abort.res_valid", 64'(res_valid), 64'd0);
        check_eq("abort.result", 64'(result), 64'd0);
        check_eq("abort.cout", 64'(cout), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("abort.start_ready", 64'(start_ready), 64'd1);
        run_op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0005, 1'b0, 1'b0, 0, "post_abort");

        for (int n = 0; n < 40; n++) begin
            ra = rand_bcd($urandom_range(0, 9) == 0);
            rb = rand_bcd($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
